// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types and default constants for the game timing blocks.
//   - state_t      : round state machine encoding
//   - DEF_CLK_HZ   : default input clock frequency
//   - DEF_ROUND_SECS / DEF_MAX_ROUNDS : default round length and game length
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSED    = 3'd2,
        TIMEOUT   = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int DEF_CLK_HZ     = 100_000_000;
    localparam int DEF_ROUND_SECS = 30;
    localparam int DEF_MAX_ROUNDS = 3;

endpackage

// File: rtl/tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
//   Free-running modulo-DIV counter that produces a one-cycle enable strobe
//   instead of a divided clock.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset (counter -> 0)
//     en    in  counter advances only while high; holds otherwise
//     clr   in  synchronous clear to 0, wins over en
//     tick  out high in the cycle the counter sits at DIV-1 while enabled
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Gated by en so a held count in a paused phase never fires a strobe.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/round_timer_ctrl.sv
// -----------------------------------------------------------------------------
// round_timer_ctrl
//   Per-round countdown sequencer. A tick_gen strobe decrements time_left once
//   per second while running; a five-state FSM handles pause, timeout, round
//   advance, game over and abort.
//   Ports:
//     clk, rst_n     clock / asynchronous active-low reset
//     start          pulse: IDLE or GAME_OVER -> RUN
//     pause          pulse: toggles RUN <-> PAUSED
//     abort          pulse: back to IDLE from anywhere, round 0, no timeout
//     time_left      seconds remaining in the current round
//     running        registered, high in RUN
//     paused         registered, high in PAUSED
//     timeout_pulse  one-cycle strobe in the cycle TIMEOUT is entered
//     game_over      registered, high in GAME_OVER
//     round_idx      0-based round number
//     state_dbg      current FSM state, for observation only
// -----------------------------------------------------------------------------
module round_timer_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ     = DEF_CLK_HZ,
    parameter int TICK_HZ    = 1,
    parameter int ROUND_SECS = DEF_ROUND_SECS,
    parameter int TIME_W     = 5,
    parameter int MAX_ROUNDS = DEF_MAX_ROUNDS,
    parameter int ROUND_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [TIME_W-1:0]  time_left,
    output logic               running,
    output logic               paused,
    output logic               timeout_pulse,
    output logic               game_over,
    output logic [ROUND_W-1:0] round_idx,
    output state_t             state_dbg
);

    localparam int                 DIV        = CLK_HZ / TICK_HZ;
    localparam logic [TIME_W-1:0]  SECS_INIT  = TIME_W'(ROUND_SECS);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);

    state_t state;
    state_t state_n;

    logic [TIME_W-1:0]  time_n;
    logic [ROUND_W-1:0] round_n;
    logic               running_n;
    logic               paused_n;
    logic               game_over_n;
    logic               timeout_n;

    logic tick;
    logic tick_clr;

    // The counter only runs in RUN. It is cleared whenever the FSM is outside
    // RUN/PAUSED so every fresh round starts on a whole second, while a pause
    // keeps the partial second.
    assign tick_clr = abort || !((state == RUN) || (state == PAUSED));

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RUN),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------- next state
    // Priority: abort > tick > pause > start.
    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_n = RUN;
                end
                RUN: begin
                    // A tick reaching zero beats a same-cycle pause.
                    if (tick && (time_left == TIME_W'(1))) begin
                        state_n = TIMEOUT;
                    end else if (pause) begin
                        state_n = PAUSED;
                    end
                end
                PAUSED: begin
                    if (pause) state_n = RUN;
                end
                TIMEOUT: begin
                    state_n = (round_idx == LAST_ROUND) ? GAME_OVER : IDLE;
                end
                GAME_OVER: begin
                    if (start) state_n = RUN;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        time_n  = time_left;
        round_n = round_idx;
        if (abort) begin
            time_n  = SECS_INIT;
            round_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) time_n = SECS_INIT;
                end
                RUN: begin
                    // Decrement only above zero so time_left cannot wrap.
                    if (tick && (time_left != '0)) time_n = time_left - TIME_W'(1);
                end
                TIMEOUT: begin
                    if (round_idx != LAST_ROUND) begin
                        round_n = round_idx + ROUND_W'(1);
                        time_n  = SECS_INIT;
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        round_n = '0;
                        time_n  = SECS_INIT;
                    end
                end
                default: begin
                    time_n  = time_left;
                    round_n = round_idx;
                end
            endcase
        end

        // Flags decode the next state so they line up with the state register.
        running_n   = (state_n == RUN);
        paused_n    = (state_n == PAUSED);
        game_over_n = (state_n == GAME_OVER);
        timeout_n   = (state == RUN) && (state_n == TIMEOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_left     <= SECS_INIT;
            round_idx     <= '0;
            running       <= 1'b0;
            paused        <= 1'b0;
            game_over     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            time_left     <= time_n;
            round_idx     <= round_n;
            running       <= running_n;
            paused        <= paused_n;
            game_over     <= game_over_n;
            timeout_pulse <= timeout_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_round_timer_ctrl
//   Directed bench for round_timer_ctrl with CLK_HZ=10, TICK_HZ=1,
//   ROUND_SECS=3, MAX_ROUNDS=2. A behavioural model tracks mode, seconds,
//   round and elapsed cycles of the current second; each clock it queues the
//   expected outputs and a compare process checks them on the falling edge.
//   Literal checks at hand-computed cycles pin the model.
// -----------------------------------------------------------------------------
module tb_round_timer_ctrl;
    import game_pkg::*;

    localparam int DIV   = 10;
    localparam int RS    = 3;
    localparam int MR    = 2;
    localparam int TW    = 5;
    localparam int RW    = 2;

    // ---------------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] time_left;
    logic          running;
    logic          paused;
    logic          timeout_pulse;
    logic          game_over;
    logic [RW-1:0] round_idx;
    state_t        state_dbg;

    round_timer_ctrl #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .ROUND_SECS (RS),
        .TIME_W     (TW),
        .MAX_ROUNDS (MR),
        .ROUND_W    (RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pause         (pause),
        .abort         (abort),
        .time_left     (time_left),
        .running       (running),
        .paused        (paused),
        .timeout_pulse (timeout_pulse),
        .game_over     (game_over),
        .round_idx     (round_idx),
        .state_dbg     (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- model
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_TOUT = 3, M_OVER = 4;

    typedef struct packed {
        logic [TW-1:0] t;
        logic          run;
        logic          pau;
        logic          pul;
        logic          ovr;
        logic [RW-1:0] rnd;
        state_t        st;
    } exp_t;
    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];

    int m_mode;
    int m_time;
    int m_round;
    int m_elapsed;   // cycles already spent running in the current second
    bit m_pulse;

    function automatic state_t mode_name(input int m);
        case (m)
            M_RUN:   return RUN;
            M_PAUSE: return PAUSED;
            M_TOUT:  return TIMEOUT;
            M_OVER:  return GAME_OVER;
            default: return IDLE;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        bit   second_done;
        if (!rst_n) begin
            m_mode = M_IDLE; m_time = RS; m_round = 0; m_elapsed = 0; m_pulse = 0;
            exp_q.delete();
        end else begin
            m_pulse = 0;
            if (abort) begin
                m_mode = M_IDLE; m_time = RS; m_round = 0; m_elapsed = 0;
            end else begin
                case (m_mode)
                    M_IDLE: if (start) begin
                        m_mode = M_RUN; m_time = RS; m_elapsed = 0;
                    end
                    M_RUN: begin
                        second_done = (m_elapsed == DIV - 1);
                        m_elapsed = second_done ? 0 : m_elapsed + 1;
                        if (second_done && m_time == 1) begin
                            m_time = 0; m_mode = M_TOUT; m_pulse = 1;
                        end else begin
                            if (second_done && m_time > 0) m_time = m_time - 1;
                            if (pause) m_mode = M_PAUSE;
                        end
                    end
                    M_PAUSE: if (pause) m_mode = M_RUN;
                    M_TOUT: begin
                        if (m_round == MR - 1) begin
                            m_mode = M_OVER;
                        end else begin
                            m_round = m_round + 1; m_time = RS; m_mode = M_IDLE;
                        end
                    end
                    M_OVER: if (start) begin
                        m_round = 0; m_time = RS; m_elapsed = 0; m_mode = M_RUN;
                    end
                    default: m_mode = M_IDLE;
                endcase
            end
            e.t   = TW'(m_time);
            e.run = (m_mode == M_RUN);
            e.pau = (m_mode == M_PAUSE);
            e.pul = m_pulse;
            e.ovr = (m_mode == M_OVER);
            e.rnd = RW'(m_round);
            e.st  = mode_name(m_mode);
            exp_q.push_back(e);
        end
    end

    // ---------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("time_left",     int'(time_left),     int'(e.t));
            chk("running",       int'(running),       int'(e.run));
            chk("paused",        int'(paused),        int'(e.pau));
            chk("timeout_pulse", int'(timeout_pulse), int'(e.pul));
            chk("game_over",     int'(game_over),     int'(e.ovr));
            chk("round_idx",     int'(round_idx),     int'(e.rnd));
            chk("state",         int'(state_dbg),     int'(e.st));
        end
    end

    // ---------------------------------------------------------- driver tasks
    // Inputs change just after a falling edge; each call spans one cycle.
    task automatic cyc(input bit s, input bit p, input bit a);
        start = s; pause = p; abort = a;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_time"},  int'(time_left), RS);
        chk({tag, "_run"},   int'(running), 0);
        chk({tag, "_pause"}, int'(paused), 0);
        chk({tag, "_pulse"}, int'(timeout_pulse), 0);
        chk({tag, "_over"},  int'(game_over), 0);
        chk({tag, "_round"}, int'(round_idx), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------- stimulus
    initial begin
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // 1: full round, literal cycle times
        cyc(1, 0, 0);                                   // cycle 1
        chk("t1_running_c1", int'(running), 1);
        idle(9);  chk("t1_time_c10", int'(time_left), 3);
        idle(1);  chk("t1_time_c11", int'(time_left), 2);
        idle(10); chk("t1_time_c21", int'(time_left), 1);
        idle(9);  chk("t1_pulse_c30", int'(timeout_pulse), 0);
        idle(1);  chk("t1_time_c31", int'(time_left), 0);
                  chk("t1_pulse_c31", int'(timeout_pulse), 1);
        idle(1);  chk("t1_pulse_c32", int'(timeout_pulse), 0);
                  chk("t1_round_c32", int'(round_idx), 1);
                  chk("t1_idle_c32", int'(state_dbg == IDLE), 1);

        // 2: pause preserves the partial second; then 4: game over
        cyc(1, 0, 0);
        idle(10); chk("t2_time_c11", int'(time_left), 2);
        idle(4);
        cyc(0, 1, 0);
        idle(50); chk("t2_paused_hold", int'(paused), 1);
                  chk("t2_time_hold", int'(time_left), 2);
        cyc(0, 1, 0);
        idle(4);  chk("t2_time_r5", int'(time_left), 2);
        idle(1);  chk("t2_time_r6", int'(time_left), 1);
        idle(10); chk("t2_pulse", int'(timeout_pulse), 1);
        idle(1);  chk("t4_over", int'(game_over), 1);
                  chk("t4_over_time", int'(time_left), 0);
        idle(3);  chk("t4_over_hold", int'(game_over), 1);
        cyc(1, 0, 0);
        chk("t4_restart_round", int'(round_idx), 0);
        chk("t4_restart_time", int'(time_left), 3);
        chk("t4_restart_run", int'(running), 1);

        // 3: tick and pause in the same cycle
        idle(19);
        cyc(0, 1, 0);
        chk("t3_time_1", int'(time_left), 1);
        chk("t3_paused", int'(paused), 1);
        cyc(0, 1, 0);
        idle(9);
        cyc(0, 1, 0);
        chk("t3_time_0", int'(time_left), 0);
        chk("t3_pulse", int'(timeout_pulse), 1);
        chk("t3_not_paused", int'(paused), 0);
        idle(1);
        chk("t3_round_adv", int'(round_idx), 1);

        // 5: abort while paused, then start during RUN is ignored
        cyc(1, 0, 0);
        idle(3);
        cyc(0, 1, 0);
        idle(2);
        cyc(0, 0, 1);
        chk_reset_vals("t5_abort");
        cyc(1, 0, 0);
        idle(3);
        cyc(1, 0, 0);
        idle(5);  chk("t5_time_c10", int'(time_left), 3);
        idle(1);  chk("t5_time_c11", int'(time_left), 2);

        // 6: asynchronous reset mid-round
        idle(5);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 0);
        idle(9);  chk("t6_time_c10", int'(time_left), 3);
        idle(1);  chk("t6_time_c11", int'(time_left), 2);

        // abort beats a same-cycle tick and pause
        idle(9);
        cyc(0, 1, 1);
        chk_reset_vals("abort_tick");

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
